// File: rtl/img_sram_pkg.sv
// Shared image SRAM types: control bundle and pixel/dimension widths.
package img_sram_pkg;
  localparam int IMG_DIM_W = 8;
  localparam int PIX_W     = 8;

  typedef struct packed {
    logic                 write_en;
    logic                 sense_en;
    logic [IMG_DIM_W-1:0] row;
    logic [IMG_DIM_W-1:0] col;
    logic [PIX_W-1:0]     din;
  } img_sram_ctrl_t;
endpackage

// File: rtl/img_sram_unloader_pix_fifo.sv
// Synchronous FIFO for {last, eol, data} beats; head visible combinationally.
// Push and pop in the same cycle are both honoured, including when full.
module pix_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 10
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  assert property (@(posedge clk) disable iff (!rstn) (push && full) |-> pop);
  assert property (@(posedge clk) disable iff (!rstn) pop |-> !empty);
endmodule

// File: rtl/img_sram_unloader.sv
// Streams an image out of buffer SRAM in raster order (optionally transposed).
// First beat valid two edges after start; reads are credit-limited so m_ready stalls never overflow the FIFO.
module img_sram_unloader
  import img_sram_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [IMG_DIM_W-1:0] nrows,
  input  logic [IMG_DIM_W-1:0] ncols,
  input  logic                 transpose,
  output logic                 busy,
  output logic                 done,
  input  logic [PIX_W-1:0]     sram_dout_in,
  output img_sram_ctrl_t       sram_ctrl,
  output logic [PIX_W-1:0]     m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_eol,
  output logic                 m_last
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] READ   = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [1:0]           state;
  logic [IMG_DIM_W-1:0] nrows_q, ncols_q, r, c, row_hold, col_hold, cur_row, cur_col;
  logic                 tr_q, inflight, inf_eol, inf_last;
  logic                 pop, issue, last_col, last_row;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_full, fifo_empty;
  logic [PIX_W+1:0]     fifo_dout;
  logic [CW:0]          occupied, room;

  assign pop      = m_valid & m_ready;
  // Slots already claimed (stored + in flight) must leave room for one more read.
  assign occupied = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign room     = (CW+1)'(FIFO_DEPTH) + {{CW{1'b0}}, pop};
  assign issue    = (state == READ) && (occupied < room);
  assign last_col = (c == ncols_q - IMG_DIM_W'(1));
  assign last_row = (r == nrows_q - IMG_DIM_W'(1));
  assign cur_row  = tr_q ? c : r;
  assign cur_col  = tr_q ? r : c;

  always_comb begin
    sram_ctrl = '0;
    if (state != IDLE) begin
      sram_ctrl.row = issue ? cur_row : row_hold;
      sram_ctrl.col = issue ? cur_col : col_hold;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      nrows_q  <= '0;
      ncols_q  <= '0;
      tr_q     <= 1'b0;
      r        <= '0;
      c        <= '0;
      row_hold <= '0;
      col_hold <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          nrows_q  <= nrows;
          ncols_q  <= ncols;
          tr_q     <= transpose;
          r        <= '0;
          c        <= '0;
          row_hold <= '0;
          col_hold <= '0;
          state    <= (nrows == '0 || ncols == '0) ? FINISH : READ;
        end
        READ: if (issue) begin
          row_hold <= cur_row;
          col_hold <= cur_col;
          if (last_col) begin
            c <= '0;
            if (last_row) state <= DRAIN;
            else          r     <= r + IMG_DIM_W'(1);
          end else begin
            c <= c + IMG_DIM_W'(1);
          end
        end
        // Leave only once the final beat is being accepted, so done lands right after it.
        DRAIN: if (!inflight && (fifo_empty || (fifo_count == CW'(1) && pop))) state <= FINISH;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight <= 1'b0;
      inf_eol  <= 1'b0;
      inf_last <= 1'b0;
    end else begin
      inflight <= issue;
      inf_eol  <= issue & last_col;
      inf_last <= issue & last_col & last_row;
    end
  end

  pix_fifo #(.DEPTH(FIFO_DEPTH), .W(PIX_W + 2)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (inflight),
    .din   ({inf_last, inf_eol, sram_dout_in}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m_valid                 = !fifo_empty;
  assign {m_last, m_eol, m_data} = fifo_dout;
  assign busy                    = (state == READ) || (state == DRAIN);
  assign done                    = (state == FINISH);

  assert property (@(posedge clk) disable iff (!rstn) (fifo_full && !pop) |-> !issue);
endmodule

// File: tb/tb_img_sram_unloader.sv
// Scoreboard bench for img_sram_unloader: expected beats queued at start, monitor pops on each handshake.
module tb_img_sram_unloader;
  import img_sram_pkg::*;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           start = 1'b0;
  logic [7:0]     nrows = '0;
  logic [7:0]     ncols = '0;
  logic           transpose = 1'b0;
  logic           busy, done;
  logic [7:0]     sram_dout_in = '0;
  img_sram_ctrl_t sram_ctrl;
  logic [7:0]     m_data;
  logic           m_valid;
  logic           m_ready = 1'b1;
  logic           m_eol, m_last;

  img_sram_unloader #(.FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .nrows        (nrows),
    .ncols        (ncols),
    .transpose    (transpose),
    .busy         (busy),
    .done         (done),
    .sram_dout_in (sram_dout_in),
    .sram_ctrl    (sram_ctrl),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_eol        (m_eol),
    .m_last       (m_last)
  );

  always #5 clk = ~clk;

  // SRAM contents are a linear function of the physical address; read data lags the address by one cycle.
  int pix_a = 16;
  int pix_b = 1;
  always @(posedge clk) sram_dout_in <= 8'(pix_a * int'(sram_ctrl.row) + pix_b * int'(sram_ctrl.col));

  typedef struct packed {
    logic [7:0] data;
    logic       eol;
    logic       last;
  } beat_t;

  beat_t sb[$];
  int    n_pass = 0;
  int    n_total = 0;
  int    n_beats = 0;
  int    done_cnt = 0;
  bit    done_due = 1'b0;
  bit    prev_stall = 1'b0;
  beat_t prev_beat;
  int    ready_mode = 0;
  int    cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall = 1'b0;
      done_due   = 1'b0;
    end else begin
      check("sram_read_only", int'({sram_ctrl.write_en, sram_ctrl.sense_en, sram_ctrl.din}), 0);
      if (done) done_cnt++;
      if (done_due) begin
        check("done_after_last", int'(done), 1);
        done_due = 1'b0;
      end
      if (prev_stall) begin
        check("stall_valid", int'(m_valid), 1);
        check("stall_hold", int'({m_data, m_eol, m_last}), int'(prev_beat));
      end
      if (m_valid && m_ready) begin
        n_beats++;
        check("beat_expected", (sb.size() > 0) ? 1 : 0, 1);
        if (sb.size() > 0) begin
          beat_t e;
          e = sb.pop_front();
          check("beat_data", int'(m_data), int'(e.data));
          check("beat_eol", int'(m_eol), int'(e.eol));
          check("beat_last", int'(m_last), int'(e.last));
        end
        if (m_last) done_due = 1'b1;
      end
      prev_stall = m_valid && !m_ready;
      prev_beat  = '{data: m_data, eol: m_eol, last: m_last};
    end
  end

  // Ready driver: mode 0 always ready; mode 1 random with a forced 10-cycle stall every 40 cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ((cyc % 40) >= 20 && (cyc % 40) < 30) ? 1'b0 : 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  task automatic push_exp(input int nr, input int nc, input bit tr, input int a, input int b);
    for (int r = 0; r < nr; r++) begin
      for (int c = 0; c < nc; c++) begin
        beat_t e;
        int row, col;
        row = tr ? c : r;
        col = tr ? r : c;
        e.data = 8'(a * row + b * col);
        e.eol  = (c == nc - 1);
        e.last = (c == nc - 1) && (r == nr - 1);
        sb.push_back(e);
      end
    end
  endtask

  // Returns just after the edge that samples start; inputs are then scrambled to prove they were latched.
  task automatic do_start(input int nr, input int nc, input bit tr);
    @(posedge clk);
    #1;
    nrows = 8'(nr);
    ncols = 8'(nc);
    transpose = tr;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nrows = 8'hA5;
    ncols = 8'h5A;
    transpose = ~tr;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("done_seen", int'(done), 1);
  endtask

  task automatic finish_test(input string name, input int exp_done);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check({name, "_done_count"}, done_cnt, exp_done);
    check({name, "_busy_after"}, int'(busy), 0);
    check({name, "_beats_left"}, sb.size(), 0);
    sb.delete();
    done_cnt = 0;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_done"}, int'(done), 0);
    check({name, "_m_valid"}, int'(m_valid), 0);
    check({name, "_m_data"}, int'(m_data), 0);
    check({name, "_m_eol"}, int'(m_eol), 0);
    check({name, "_m_last"}, int'(m_last), 0);
    check({name, "_row"}, int'(sram_ctrl.row), 0);
    check({name, "_col"}, int'(sram_ctrl.col), 0);
  endtask

  initial begin
    int base;
    int n;
    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 4x6 raster, full throughput: latency and contiguity checked directly.
    pix_a = 16; pix_b = 1;
    push_exp(4, 6, 1'b0, 16, 1);
    do_start(4, 6, 1'b0);
    check("lat_busy_e0", int'(busy), 1);
    check("lat_valid_e0", int'(m_valid), 0);
    @(posedge clk); #1;
    check("lat_valid_e1", int'(m_valid), 0);
    @(posedge clk); #1;
    for (int i = 0; i < 24; i++) begin
      check("contiguous_valid", int'(m_valid), 1);
      @(posedge clk); #1;
    end
    check("done_timing", int'(done), 1);
    wait_done(10);
    finish_test("raster", 1);

    // Same image under random backpressure.
    ready_mode = 1;
    push_exp(4, 6, 1'b0, 16, 1);
    do_start(4, 6, 1'b0);
    wait_done(600);
    ready_mode = 0;
    finish_test("stall", 1);

    // Transposed 3x5 read.
    pix_a = 10; pix_b = 1;
    push_exp(3, 5, 1'b1, 10, 1);
    do_start(3, 5, 1'b1);
    wait_done(200);
    finish_test("transpose", 1);

    // Degenerate dimensions.
    do_start(0, 5, 1'b0);
    wait_done(10);
    finish_test("zero_rows", 1);
    do_start(5, 0, 1'b0);
    wait_done(10);
    finish_test("zero_cols", 1);
    pix_a = 16; pix_b = 1;
    push_exp(1, 1, 1'b0, 16, 1);
    do_start(1, 1, 1'b0);
    wait_done(20);
    finish_test("one_pixel", 1);

    // start re-pulsed mid-unload with other dims is ignored.
    push_exp(4, 6, 1'b0, 16, 1);
    do_start(4, 6, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    nrows = 8'd2; ncols = 8'd2; transpose = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(200);
    finish_test("restart_ignored", 1);

    // Reset after ten beats abandons the stream; a fresh start begins at (0,0).
    push_exp(4, 6, 1'b0, 16, 1);
    base = n_beats;
    do_start(4, 6, 1'b0);
    n = 0;
    while (n_beats < base + 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ten_beats_seen", (n_beats >= base + 10) ? 1 : 0, 1);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    sb.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mid_reset_no_done", done_cnt, 0);
    push_exp(4, 6, 1'b0, 16, 1);
    do_start(4, 6, 1'b0);
    wait_done(200);
    finish_test("after_reset", 1);

    // 255x255 full-size unload; the final beat's data checks address (254,254).
    pix_a = 7; pix_b = 3;
    push_exp(255, 255, 1'b0, 7, 3);
    do_start(255, 255, 1'b0);
    wait_done(70000);
    finish_test("max_dims", 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
